// File: rtl/replay_agg_if.sv
// Replay aggregator bus: per-slot valid sources in, replay/flush control out.
// Latency: wires only; timing is defined by replay_agg.
// Backpressure: none on io_valid; io_ack closes an outstanding replay.
//
// Ports (as seen by the aggregator, modport slave):
//    io_valid      in   NUM_BLOCKS  per-slot valid/event input
//    io_ack        in   1           consumer acknowledges the replay
//    io_replay     out  1           replay request, held until ack or timeout
//    io_busy       out  1           aggregator not idle
//    io_timeout    out  1           sticky timeout flag
//    io_replay_cnt out  CNT_W       saturating count of replays issued
interface replay_agg_if #(
   parameter int NUM_BLOCKS = 3,
   parameter int CNT_W      = 8
);
   logic [NUM_BLOCKS-1:0] io_valid;
   logic                  io_ack;
   logic                  io_replay;
   logic                  io_busy;
   logic                  io_timeout;
   logic [CNT_W-1:0]      io_replay_cnt;

   // Driver side: pipeline stages and replay consumer.
   modport master (
      output io_valid,
      output io_ack,
      input  io_replay,
      input  io_busy,
      input  io_timeout,
      input  io_replay_cnt
   );

   // Aggregator side.
   modport slave (
      input  io_valid,
      input  io_ack,
      output io_replay,
      output io_busy,
      output io_timeout,
      output io_replay_cnt
   );
endinterface

// File: rtl/replay_agg.sv
// Replay aggregator: reduces N per-slot requests into one held replay pulse.
// Latency: trigger sampled at edge t raises io_replay from t+1 (REG slots add one).
// Backpressure: io_replay held until io_ack or timeout, then HOLDOFF dead cycles.
//
// Ports:
//    clk    in   1  clock
//    reset  in   1  asynchronous, active-high reset
//    bus    slave modport of replay_agg_if (io_valid, io_ack in;
//           io_replay, io_busy, io_timeout, io_replay_cnt out)
module replay_agg #(
   parameter int                    NUM_BLOCKS = 3,
   parameter logic [2*NUM_BLOCKS-1:0] MODES    = 6'b10_01_01,
   parameter bit                    REDUCE_AND = 1'b1,
   parameter int                    TIMEOUT    = 15,
   parameter int                    HOLDOFF    = 2,
   parameter int                    CNT_W      = 8
) (
   input  logic         clk,
   input  logic         reset,
   replay_agg_if.slave  bus
);

   // Per-slot behaviour encodings (2 bits per slot in MODES).
   localparam logic [1:0] MODE_NEVER  = 2'd0;
   localparam logic [1:0] MODE_COMB   = 2'd1;
   localparam logic [1:0] MODE_REG    = 2'd2;
   localparam logic [1:0] MODE_STICKY = 2'd3;

   localparam logic [7:0] TMO_LOAD  = 8'(TIMEOUT);
   localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REPLAY = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            tmo_q, tmo_d;
   logic [7:0]            hold_q, hold_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tout_q, tout_d;

   // One flop per slot; only REG and STICKY slots give it a meaning,
   // the others keep it tied at zero so it folds away.
   logic [NUM_BLOCKS-1:0] slot_q, slot_d;

   logic [NUM_BLOCKS-1:0] req;        // per-slot request r[i]
   logic [NUM_BLOCKS-1:0] and_term;   // AND operand: NEVER slots forced to 1
   logic                  any_active; // at least one slot is not NEVER
   logic                  trigger;
   logic                  start;      // IDLE->REPLAY transition this cycle

   // ------------------------------------------------------------------
   // Slot requests
   // ------------------------------------------------------------------
   always_comb begin
      req        = '0;
      and_term   = '0;
      any_active = 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         case (MODES[2*i +: 2])
            MODE_NEVER: begin
               req[i]      = 1'b0;
               and_term[i] = 1'b1;
            end
            MODE_COMB: begin
               req[i]      = bus.io_valid[i];
               and_term[i] = bus.io_valid[i];
               any_active  = 1'b1;
            end
            default: begin
               // REG and STICKY both present the slot flop.
               req[i]      = slot_q[i];
               and_term[i] = slot_q[i];
               any_active  = 1'b1;
            end
         endcase
      end
   end

   // An all-NEVER configuration must not fire through the empty AND.
   assign trigger = REDUCE_AND ? (any_active & (&and_term)) : (|req);

   // Slot flop next-state. STICKY clears on the start cycle, but a new
   // event arriving in that same cycle wins so it is not lost.
   always_comb begin
      slot_d = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         case (MODES[2*i +: 2])
            MODE_REG:    slot_d[i] = bus.io_valid[i];
            MODE_STICKY: slot_d[i] = bus.io_valid[i] | (slot_q[i] & ~start);
            default:     slot_d[i] = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Handshake FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      tout_d  = tout_q;
      start   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               start   = 1'b1;
               state_d = ST_REPLAY;
               tmo_d   = TMO_LOAD;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_REPLAY: begin
            // tmo_q counts the remaining no-ack cycles after this one;
            // reaching zero without ack ends the replay. Ack is tested
            // first so it wins over a simultaneous expiry.
            if (bus.io_ack || (tmo_q == 8'd0)) begin
               if (!bus.io_ack) begin
                  tout_d = 1'b1;
               end
               hold_d  = HOLD_LOAD;
               state_d = (HOLD_LOAD == 8'd0) ? ST_IDLE : ST_HOLD;
            end else begin
               tmo_d = tmo_q - 8'd1;
            end
         end

         ST_HOLD: begin
            // hold_q holds the dead cycles left including this one.
            hold_d = (hold_q == 8'd0) ? 8'd0 : (hold_q - 8'd1);
            if (hold_q <= 8'd1) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tmo_q   <= 8'd0;
         hold_q  <= 8'd0;
         cnt_q   <= '0;
         tout_q  <= 1'b0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
         slot_q  <= slot_d;
      end
   end

   // Outputs decode registered state only, so reset drops them at once.
   assign bus.io_replay     = (state_q == ST_REPLAY);
   assign bus.io_busy       = (state_q != ST_IDLE);
   assign bus.io_timeout    = tout_q;
   assign bus.io_replay_cnt = cnt_q;

endmodule

// File: tb/tb_replay_agg.sv
// Directed bench for replay_agg across several parameter sets.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: io_ack driven directly by the bench.
module tb_replay_agg;

   logic clk;
   logic reset;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A: defaults. B: all STICKY. C: 2-bit counter. D: all NEVER.
   // E: OR reduction, slot 0 COMB, others NEVER.
   replay_agg_if #(.NUM_BLOCKS(3), .CNT_W(8)) if_a ();
   replay_agg_if #(.NUM_BLOCKS(3), .CNT_W(8)) if_b ();
   replay_agg_if #(.NUM_BLOCKS(3), .CNT_W(2)) if_c ();
   replay_agg_if #(.NUM_BLOCKS(3), .CNT_W(8)) if_d ();
   replay_agg_if #(.NUM_BLOCKS(3), .CNT_W(8)) if_e ();

   replay_agg #(.NUM_BLOCKS(3), .MODES(6'b10_01_01), .REDUCE_AND(1'b1),
                .TIMEOUT(15), .HOLDOFF(2), .CNT_W(8))
      dut_a (.clk(clk), .reset(reset), .bus(if_a));
   replay_agg #(.NUM_BLOCKS(3), .MODES(6'b11_11_11), .REDUCE_AND(1'b1),
                .TIMEOUT(15), .HOLDOFF(2), .CNT_W(8))
      dut_b (.clk(clk), .reset(reset), .bus(if_b));
   replay_agg #(.NUM_BLOCKS(3), .MODES(6'b10_01_01), .REDUCE_AND(1'b1),
                .TIMEOUT(15), .HOLDOFF(2), .CNT_W(2))
      dut_c (.clk(clk), .reset(reset), .bus(if_c));
   replay_agg #(.NUM_BLOCKS(3), .MODES(6'b00_00_00), .REDUCE_AND(1'b1),
                .TIMEOUT(15), .HOLDOFF(2), .CNT_W(8))
      dut_d (.clk(clk), .reset(reset), .bus(if_d));
   replay_agg #(.NUM_BLOCKS(3), .MODES(6'b00_00_01), .REDUCE_AND(1'b0),
                .TIMEOUT(15), .HOLDOFF(2), .CNT_W(8))
      dut_e (.clk(clk), .reset(reset), .bus(if_e));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Both start tasks leave the DUT in its first REPLAY cycle.
   task automatic a_start();
      if_a.io_valid = 3'b111;
      tick();
      tick();
      if_a.io_valid = 3'b000;
   endtask

   task automatic c_start();
      if_c.io_valid = 3'b111;
      tick();
      tick();
      if_c.io_valid = 3'b000;
   endtask

   // Ack, then ride out the two HOLD cycles back to IDLE.
   task automatic a_ack_idle();
      if_a.io_ack = 1'b1;
      tick();
      if_a.io_ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic c_ack_idle();
      if_c.io_ack = 1'b1;
      tick();
      if_c.io_ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic b_ack_idle();
      if_b.io_ack = 1'b1;
      tick();
      if_b.io_ack = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      int exp_cnt [5] = '{1, 2, 3, 3, 3};

      if_a.io_valid = '0; if_a.io_ack = 1'b0;
      if_b.io_valid = '0; if_b.io_ack = 1'b0;
      if_c.io_valid = '0; if_c.io_ack = 1'b0;
      if_d.io_valid = '0; if_d.io_ack = 1'b0;
      if_e.io_valid = '0; if_e.io_ack = 1'b0;
      reset = 1'b1;
      #12;
      chk("rst_replay",  32'(if_a.io_replay), 32'd0);
      chk("rst_busy",    32'(if_a.io_busy), 32'd0);
      chk("rst_timeout", 32'(if_a.io_timeout), 32'd0);
      chk("rst_cnt",     32'(if_a.io_replay_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Single-cycle pulse: REG slot lags, AND never satisfied.
      if_a.io_valid = 3'b111;
      tick();
      if_a.io_valid = 3'b000;
      chk("pulse_no_rep0", 32'(if_a.io_replay), 32'd0);
      tick();
      chk("pulse_no_rep1", 32'(if_a.io_replay), 32'd0);
      tick();
      chk("pulse_no_busy", 32'(if_a.io_busy), 32'd0);

      // Two-cycle hold: replay from t+2.
      if_a.io_valid = 3'b111;
      tick();
      chk("hold2_not_early", 32'(if_a.io_replay), 32'd0);
      tick();
      if_a.io_valid = 3'b000;
      chk("hold2_replay", 32'(if_a.io_replay), 32'd1);
      chk("hold2_cnt",    32'(if_a.io_replay_cnt), 32'd1);

      // Ack on the third REPLAY cycle.
      tick();
      chk("ack_cyc2", 32'(if_a.io_replay), 32'd1);
      tick();
      chk("ack_cyc3", 32'(if_a.io_replay), 32'd1);
      if_a.io_ack = 1'b1;
      tick();
      if_a.io_ack = 1'b0;
      chk("ack_drop",  32'(if_a.io_replay), 32'd0);
      chk("ack_hold1", 32'(if_a.io_busy), 32'd1);
      tick();
      chk("ack_hold2", 32'(if_a.io_busy), 32'd1);
      tick();
      chk("ack_idle",  32'(if_a.io_busy), 32'd0);
      chk("ack_no_tmo", 32'(if_a.io_timeout), 32'd0);

      // Ack on the 16th (expiry) cycle beats the timeout.
      a_start();
      repeat (15) tick();
      chk("exp_last_cyc", 32'(if_a.io_replay), 32'd1);
      if_a.io_ack = 1'b1;
      tick();
      if_a.io_ack = 1'b0;
      chk("exp_ack_drop",  32'(if_a.io_replay), 32'd0);
      chk("exp_ack_no_tmo", 32'(if_a.io_timeout), 32'd0);
      tick();
      tick();

      // No ack: replay lasts 16 cycles, then sticky timeout.
      a_start();
      n = 1;
      for (int k = 0; k < 40 && if_a.io_replay; k++) begin
         tick();
         if (if_a.io_replay) n++;
      end
      chk("tmo_len", 32'(n), 32'd16);
      chk("tmo_flag", 32'(if_a.io_timeout), 32'd1);
      tick();
      tick();
      chk("tmo_idle", 32'(if_a.io_busy), 32'd0);
      a_start();
      a_ack_idle();
      chk("tmo_sticky", 32'(if_a.io_timeout), 32'd1);
      chk("a_cnt4",     32'(if_a.io_replay_cnt), 32'd4);

      // STICKY slots, round 1: replay one cycle after the last pulse.
      if_b.io_valid = 3'b001; tick();
      if_b.io_valid = 3'b010; tick();
      if_b.io_valid = 3'b100; tick();
      if_b.io_valid = 3'b000;
      chk("stk_wait", 32'(if_b.io_replay), 32'd0);
      tick();
      chk("stk_fire", 32'(if_b.io_replay), 32'd1);
      b_ack_idle();
      repeat (3) tick();
      chk("stk_cleared", 32'(if_b.io_busy), 32'd0);
      chk("stk_cnt1",    32'(if_b.io_replay_cnt), 32'd1);

      // Round 2: re-pulse slot 0 on the clear cycle; it must survive.
      if_b.io_valid = 3'b001; tick();
      if_b.io_valid = 3'b010; tick();
      if_b.io_valid = 3'b100; tick();
      if_b.io_valid = 3'b001; tick();
      if_b.io_valid = 3'b000;
      chk("stk_fire2", 32'(if_b.io_replay), 32'd1);
      b_ack_idle();
      chk("stk_idle2", 32'(if_b.io_busy), 32'd0);
      if_b.io_valid = 3'b010; tick();
      if_b.io_valid = 3'b100; tick();
      if_b.io_valid = 3'b000;
      tick();
      chk("stk_retained", 32'(if_b.io_replay), 32'd1);
      chk("stk_cnt3",     32'(if_b.io_replay_cnt), 32'd3);
      b_ack_idle();

      // Saturating 2-bit counter.
      for (int k = 0; k < 5; k++) begin
         c_start();
         chk($sformatf("sat_cnt%0d", k), 32'(if_c.io_replay_cnt), 32'(exp_cnt[k]));
         c_ack_idle();
      end

      // Asynchronous reset mid-REPLAY.
      c_start();
      chk("arst_pre", 32'(if_c.io_replay), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_replay", 32'(if_c.io_replay), 32'd0);
      chk("arst_cnt",    32'(if_c.io_replay_cnt), 32'd0);
      chk("arst_busy",   32'(if_c.io_busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // All NEVER with AND: never fires.
      if_d.io_valid = 3'b111;
      bad = 0;
      repeat (20) begin
         tick();
         if (if_d.io_replay || if_d.io_busy) bad++;
      end
      if_d.io_valid = 3'b000;
      chk("never_quiet", 32'(bad), 32'd0);

      // OR reduction, single COMB slot: one pulse, one replay.
      if_e.io_valid = 3'b001;
      tick();
      if_e.io_valid = 3'b000;
      chk("or_fire", 32'(if_e.io_replay), 32'd1);
      if_e.io_ack = 1'b1;
      tick();
      if_e.io_ack = 1'b0;
      repeat (7) tick();
      chk("or_single", 32'(if_e.io_replay_cnt), 32'd1);
      chk("or_idle",   32'(if_e.io_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
